addr_gen_wu_burst: RTL and testbench

ADDR_GEN_WU_BURST -- requirements
Module: addr_gen_wu_burst

---
 rtl/addr_gen_wu_burst.sv | 141 ++++++++++++++
 tb/tb_addr_gen_wu_burst.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_wu_burst.sv
// Row-major burst address generator: ROWS rows of ROW_LEN beats spaced ROW_STRIDE apart,
// with an optional en-counted idle gap after each row and optional looping of the whole pass.
module addr_gen_wu_burst #(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE       = 0,
    parameter int ROW_LEN    = 53,
    parameter int ROWS       = 53,
    parameter int ROW_STRIDE = 53,
    parameter int PAUSE_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  i_loop,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    output logic                  o_row_last,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ROW_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           col, col_n;
    logic [RW-1:0]           row, row_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n;
    logic [ADDR_WIDTH-1:0]   row_start, row_start_n;
    logic                    col_end, row_end, pause_end;

    assign col_end = (col == CW'(ROW_LEN - 1));
    assign row_end = (row == RW'(ROWS - 1));

    // Pause counter only exists when a gap is configured; it sits at 0 outside PAUSE.
    generate
        if (PAUSE_LEN > 0) begin : g_pause
            localparam int PW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;
            logic [PW-1:0] pcnt;

            assign pause_end = (pcnt == PW'(PAUSE_LEN - 1));

            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    pcnt <= '0;
                end else if (state == S_PAUSE && en) begin
                    pcnt <= pause_end ? '0 : pcnt + 1'b1;
                end
            end
        end else begin : g_no_pause
            assign pause_end = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            addr      <= BASE_A;
            row_start <= BASE_A;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            addr      <= addr_n;
            row_start <= row_start_n;
        end
    end

    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        addr_n      = addr;
        row_start_n = row_start;
        if (clr) begin
            state_n     = S_IDLE;
            col_n       = '0;
            row_n       = '0;
            addr_n      = BASE_A;
            row_start_n = BASE_A;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n     = S_RUN;
                        col_n       = '0;
                        row_n       = '0;
                        addr_n      = BASE_A;
                        row_start_n = BASE_A;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (!col_end) begin
                            col_n  = col + 1'b1;
                            addr_n = addr + 1'b1;
                        end else if (!row_end) begin
                            // Address moves to the next row start already on entering PAUSE.
                            row_n       = row + 1'b1;
                            col_n       = '0;
                            row_start_n = row_start + STRIDE_A;
                            addr_n      = row_start + STRIDE_A;
                            state_n     = (PAUSE_LEN > 0) ? S_PAUSE : S_RUN;
                        end else if (i_loop) begin
                            row_n       = '0;
                            col_n       = '0;
                            row_start_n = BASE_A;
                            addr_n      = BASE_A;
                            state_n     = (PAUSE_LEN > 0) ? S_PAUSE : S_RUN;
                        end else begin
                            state_n = S_DONE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (en && pause_end) begin
                        state_n = S_RUN;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign o_addr     = addr;
    assign o_valid    = (state == S_RUN);
    assign o_row_last = o_valid && col_end;
    assign o_last     = o_row_last && row_end;
    assign o_busy     = (state == S_RUN) || (state == S_PAUSE);
    assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_addr_gen_wu_burst.sv
// Self-checking bench for addr_gen_wu_burst: directed scenarios plus random stimulus,
// all compared against an abstract row/column model of the pass.
module tb_addr_gen_wu_burst;

    localparam int AW = 12;
    localparam int BASE = 16;
    localparam int RL = 3;
    localparam int NR = 2;
    localparam int STRIDE = 4;
    localparam int PL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          i_loop = 1'b0;
    logic [AW-1:0] o_addr;
    logic          o_valid, o_row_last, o_last, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    addr_gen_wu_burst #(
        .ADDR_WIDTH(AW), .BASE(BASE), .ROW_LEN(RL),
        .ROWS(NR), .ROW_STRIDE(STRIDE), .PAUSE_LEN(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .clr(clr), .i_loop(i_loop),
        .o_addr(o_addr), .o_valid(o_valid), .o_row_last(o_row_last),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 run, 2 pause, 3 done; (m_r, m_c) is the beat position.
    int m_ph = 0;
    int m_r = 0;
    int m_c = 0;
    int m_p = 0;

    function automatic int addr_of(input int r, input int c);
        return (BASE + r * STRIDE + c) % (1 << AW);
    endfunction

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r_n, input logic c, input logic s,
                              input logic e, input logic l);
        if (!r_n || c) begin
            m_ph = 0; m_r = 0; m_c = 0; m_p = 0;
        end else if (s && (m_ph == 0 || m_ph == 3)) begin
            m_ph = 1; m_r = 0; m_c = 0; m_p = 0;
        end else if (e && m_ph == 1) begin
            if (m_c < RL - 1) begin
                m_c++;
            end else if (m_r < NR - 1) begin
                m_r++; m_c = 0; m_p = 0;
                m_ph = (PL > 0) ? 2 : 1;
            end else if (l) begin
                m_r = 0; m_c = 0; m_p = 0;
                m_ph = (PL > 0) ? 2 : 1;
            end else begin
                m_ph = 3;
            end
        end else if (e && m_ph == 2) begin
            m_p++;
            if (m_p == PL) m_ph = 1;
        end
    endtask

    task automatic compare_all();
        int exp_addr;
        logic ev, erl;
        ev  = (m_ph == 1);
        erl = ev && (m_c == RL - 1);
        chk("valid", o_valid, ev);
        chk("busy", o_busy, (m_ph == 1 || m_ph == 2));
        chk("done", o_done, (m_ph == 3));
        chk("row_last", o_row_last, erl);
        chk("last", o_last, erl && (m_r == NR - 1));
        if (m_ph != 2) begin
            if (m_ph == 0) exp_addr = BASE;
            else if (m_ph == 3) exp_addr = addr_of(NR - 1, RL - 1);
            else exp_addr = addr_of(m_r, m_c);
            chk("addr", o_addr, exp_addr);
        end
    endtask

    task automatic tick(input logic r_n, input logic c, input logic s,
                        input logic e, input logic l);
        rst = r_n; clr = c; start = s; en = e; i_loop = l;
        @(posedge clk);
        model_step(r_n, c, s, e, l);
        #1;
        compare_all();
    endtask

    int ev_t[10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int ea_t[10] = '{0, 16, 17, 18, 0, 0, 20, 21, 22, 22};
    int er_t[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int el_t[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        bit found;
        // Reset with other inputs active
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_addr", o_addr, BASE);
        chk("rst_busy", o_busy, 0);

        // Full pass, constant en
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            chk("seq_valid", o_valid, ev_t[k]);
            if (ev_t[k] != 0) chk("seq_addr", o_addr, ea_t[k]);
            chk("seq_row_last", o_row_last, er_t[k]);
            chk("seq_last", o_last, el_t[k]);
            chk("seq_done", o_done, (k == 9) ? 1 : 0);
            tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Stall at 17 and inside the pause; start during RUN ignored
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_pre", o_addr, 17);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_hold", o_addr, 17);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_stall_valid", o_valid, 0);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Loop: through the final beat and back to BASE
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("loop_gap", o_valid, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("loop_addr", o_addr, 16);
        chk("loop_valid", o_valid, 1);
        chk("loop_done", o_done, 0);

        // Abort at 21 and restart
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (o_valid && o_addr == 21) found = 1;
            else tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("wait_21", found, 1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_addr", o_addr, 16);
        chk("clr_busy", o_busy, 0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_addr", o_addr, 16);

        // Reset mid-PAUSE
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("in_pause", o_busy && !o_valid, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_pause_busy", o_busy, 0);
        chk("rst_pause_addr", o_addr, BASE);

        // start and clr together
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("start_clr_busy", o_busy, 0);

        // Random stimulus
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(99) != 0), ($urandom_range(59) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                 $urandom_range(1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
